matrix_key_scan: RTL and testbench
==================================

Name: matrix_key_scan

Overview:
Scans a 4x4 active-low matrix keypad and produces debounced key events for the clock's mode, adjust and set logic. It is the input-side counterpart of the time-multiplexed seven-segment driver: it drives one row low at a time and senses the columns. Each new press is delivered once through a valid/ack holding register.

Parameters:
DWELL_CYC, 50000, clk cycles each row is driven per scan step (1 ms at 50 MHz); minimum 4
DB_CYC, 1000000, clk cycles a pattern must stay stable to count as press or release (20 ms at 50 MHz); minimum 2

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
col_in  input  4  keypad columns, active low, pulled up externally, asynchronous
key_ack  input  1  consumer acknowledge; clears key_valid and overrun
row_out  output  4  row drive, one-cold (exactly one bit low at all times)
key_code  output  4  code of the last accepted key = row*4 + col
key_valid  output  1  high from key acceptance until key_ack
key_held  output  1  high while the accepted key is debounced-pressed
overrun  output  1  sticky; a new key was accepted while key_valid was already 1

Behaviour:
- Reset: clk and rst_n, asynchronous, active-low. Values: row_out=4'b1110, key_code=0, key_valid=0, key_held=0, overrun=0, state=SCAN, row index=0, all counters=0, synchronizer flops=4'b1111.
- col_in passes through a 2-flop synchronizer. In this section, "cols" means the synchronized value.
- SCAN:
  - Drive row r (row_out bit r low). The dwell counter runs 0..DWELL_CYC-1.
  - Sample cols only on the cycle where dwell==DWELL_CYC-1. This gives the row time to settle.
  - If exactly one col bit is low: latch r and col index c, keep the same row driven, clear the debounce counter, go to DEB_PRESS.
  - Otherwise (none low, or two or more low): advance r = (r+1) mod 4 (3 wraps to 0), reset dwell, stay in SCAN.
- DEB_PRESS:
  - Row is held. The debounce counter increments each cycle.
  - If cols differs from the latched one-cold pattern on any cycle: go to SCAN with the next row (r+1 mod 4), no event.
  - When the counter reaches DB_CYC-1 with the pattern still matching: accept the key and go to PRESSED. key_held=1 in the next cycle.
- PRESSED:
  - Row is held. key_held=1.
  - When cols==4'b1111: clear the counter and go to DEB_REL.
  - A change to a different non-idle pattern is ignored. No new event is produced while in PRESSED.
- DEB_REL:
  - Row is held. key_held stays 1.
  - If any col goes low: return to PRESSED, no event.
  - When cols has been all-high for DB_CYC cycles: key_held=0 and go to SCAN at row 0 with dwell 0.
- Accept event (one cycle, registered):
  - key_code <= {r[1:0], c[1:0]} and key_valid <= 1.
  - If key_valid was already 1 and key_ack=0: overrun <= 1, and the new code overwrites the old one (newest wins).
- key_ack:
  - key_ack with no event in the same cycle: key_valid <= 0, overrun <= 0.
  - key_ack in the same cycle as an event: key_valid stays 1, key_code takes the new code, overrun <= 0.
  - key_ack while key_valid=0 has no effect.
- Latency:
  - A key held from the start of its row's dwell is accepted DB_CYC cycles after the dwell-end sample.
  - key_valid rises 1 cycle after that, plus 2 cycles of synchronizer delay from the col_in edge.
- Reset mid-operation: immediately returns to the reset values. No event is generated.
- All counters are sized with $clog2 of their parameter. Counters saturate at nothing and wrap at nothing; they are always cleared on state change.

Decomposition:
- Shared package (clock_pkg):
  - state enum SCAN/DEB_PRESS/PRESSED/DEB_REL
  - ROW_DRIVE constant array {4'b1110, 4'b1101, 4'b1011, 4'b0111}
  - KEY_W=4 and named key codes used by mode logic (e.g. KEY_MODE=4'd0, KEY_SET=4'd1)
- One sub-module: sync_2ff (parameterized width, reset value all-ones), reused for other asynchronous pins.

Test Plan:
- Bench parameters for all scenarios: DWELL_CYC=4, DB_CYC=16.
- Idle, no key: row_out cycles 1110→1101→1011→0111→1110 every 4 clk; key_valid stays 0 for 200 cycles.
- Press row2/col1, hold 40 cycles, then release:
  - key_code=4'd9 and key_valid=1 exactly once.
  - key_held rises after acceptance and falls 16 cycles after release.
  - The next scan starts at 1110.
- Bounce on row1/col3 (low 5 cycles, high 2, low 40): first attempt aborts with no event. A later scan accepts code 4'd7, with a single key_valid rise.
- Two keys in the same row (col_in=4'b1010 while row 0 is driven): no event; the scan keeps advancing.
- Overrun handling:
  - Accept code 4'd2, no ack; press and release, then accept 4'd15 → key_code=15, overrun=1.
  - key_ack → key_valid=0, overrun=0.
  - Also check key_ack asserted on the accept cycle → key_valid=1, overrun=0.
- Reset asserted during DEB_REL: all outputs return to reset values immediately. After release of rst_n, row_out=1110 with no spurious event.

Source files
------------

// File: rtl/matrix_key_scan_pkg.sv
// Shared types and constants for the keypad scanner.
// Row drive table, scan states and named key codes.
package matrix_key_scan_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEB_PRESS,
    PRESSED,
    DEB_REL
  } state_e;

  localparam int KEY_W = 4;

  localparam logic [3:0] ROW_DRIVE [4] = '{
    4'b1110,
    4'b1101,
    4'b1011,
    4'b0111
  };

  localparam logic [KEY_W-1:0] KEY_MODE = 4'd0;
  localparam logic [KEY_W-1:0] KEY_SET  = 4'd1;
  localparam logic [KEY_W-1:0] KEY_UP   = 4'd2;
  localparam logic [KEY_W-1:0] KEY_DOWN = 4'd3;

  // True when exactly one column is pulled low.
  function automatic logic one_cold(
    input logic [3:0] p
  );
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (!p[i]) n++;
    end
    return (n == 1);
  endfunction

  // Index of the low column; only meaningful when one_cold(p).
  function automatic logic [1:0] cold_idx(
    input logic [3:0] p
  );
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!p[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/matrix_key_scan_if.sv
// Key event bundle between the scanner and its consumer.
// The scanner is master; the mode/set logic is slave.
interface matrix_key_scan_if;
  import matrix_key_scan_pkg::*;

  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic             key_held;
  logic             overrun;
  logic             key_ack;

  modport master (
    output key_code,
    output key_valid,
    output key_held,
    output overrun,
    input  key_ack
  );

  modport slave (
    input  key_code,
    input  key_valid,
    input  key_held,
    input  overrun,
    output key_ack
  );

endinterface

// File: rtl/matrix_key_scan_sync_2ff.sv
// Two-flop synchronizer for asynchronous input pins.
// Resets to all-ones so idle pulled-up pins read inactive.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Shift the pin through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/matrix_key_scan.sv
// 4x4 active-low keypad scanner with debounce.
// One event per press, held in a valid/ack register.
module matrix_key_scan
  import matrix_key_scan_pkg::*;
#(
  parameter int DWELL_CYC = 50000,
  parameter int DB_CYC    = 1000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          col_in,
  output logic [3:0]          row_out,
  matrix_key_scan_if.master   kbd
);

  localparam int DW = $clog2(DWELL_CYC);
  localparam int BW = $clog2(DB_CYC);

  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYC - 1);
  localparam logic [BW-1:0] DB_LAST    = BW'(DB_CYC - 1);

  logic [3:0]       w_cols;

  state_e           r_state;
  logic [1:0]       r_row;
  logic [1:0]       r_col;
  logic [DW-1:0]    r_dwell;
  logic [BW-1:0]    r_db;

  state_e           w_state;
  logic [1:0]       w_row;
  logic [1:0]       w_col;
  logic [DW-1:0]    w_dwell;
  logic [BW-1:0]    w_db;
  logic             w_accept;
  logic [KEY_W-1:0] w_code;

  logic [KEY_W-1:0] r_code;
  logic             r_valid;
  logic             r_held;
  logic             r_ovr;

  sync_2ff #(
    .WIDTH (4)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (col_in),
    .o_q   (w_cols)
  );

  assign w_code = {r_row, r_col};

  // Scan state register and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SCAN;
      r_row   <= 2'd0;
      r_col   <= 2'd0;
      r_dwell <= '0;
      r_db    <= '0;
    end else begin
      r_state <= w_state;
      r_row   <= w_row;
      r_col   <= w_col;
      r_dwell <= w_dwell;
      r_db    <= w_db;
    end
  end

  // Next-state: scan rows, debounce press, wait, debounce release.
  always_comb begin
    w_state  = r_state;
    w_row    = r_row;
    w_col    = r_col;
    w_dwell  = r_dwell;
    w_db     = r_db;
    w_accept = 1'b0;
    unique case (r_state)
      SCAN: begin
        if (r_dwell == DWELL_LAST) begin
          w_dwell = '0;
          if (one_cold(w_cols)) begin
            w_col   = cold_idx(w_cols);
            w_db    = '0;
            w_state = DEB_PRESS;
          end else begin
            w_row = r_row + 2'd1;
          end
        end else begin
          w_dwell = r_dwell + 1'b1;
        end
      end
      DEB_PRESS: begin
        if (w_cols != ROW_DRIVE[r_col]) begin
          w_row   = r_row + 2'd1;
          w_dwell = '0;
          w_db    = '0;
          w_state = SCAN;
        end else if (r_db == DB_LAST) begin
          w_accept = 1'b1;
          w_db     = '0;
          w_state  = PRESSED;
        end else begin
          w_db = r_db + 1'b1;
        end
      end
      PRESSED: begin
        if (w_cols == 4'hF) begin
          w_db    = '0;
          w_state = DEB_REL;
        end
      end
      DEB_REL: begin
        if (w_cols != 4'hF) begin
          w_db    = '0;
          w_state = PRESSED;
        end else if (r_db == DB_LAST) begin
          w_row   = 2'd0;
          w_dwell = '0;
          w_db    = '0;
          w_state = SCAN;
        end else begin
          w_db = r_db + 1'b1;
        end
      end
      default: begin
        w_state = SCAN;
      end
    endcase
  end

  // Key event register: newest code wins, ack clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (w_accept) begin
      r_code  <= w_code;
      r_valid <= 1'b1;
      if (kbd.key_ack) begin
        r_ovr <= 1'b0;
      end else if (r_valid) begin
        r_ovr <= 1'b1;
      end
    end else if (kbd.key_ack && r_valid) begin
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end
  end

  // Held flag follows the press/release debounce states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_held <= 1'b0;
    end else begin
      r_held <= (w_state == PRESSED) ||
                (w_state == DEB_REL);
    end
  end

  assign row_out       = ROW_DRIVE[r_row];
  assign kbd.key_code  = r_code;
  assign kbd.key_valid = r_valid;
  assign kbd.key_held  = r_held;
  assign kbd.overrun   = r_ovr;

endmodule

// File: tb/tb_matrix_key_scan.sv
// Directed bench for the keypad scanner.
// A row-gated key model stands in for the physical matrix.
module tb_matrix_key_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] col_in;
  logic [3:0] row_out;

  matrix_key_scan_if kif ();

  matrix_key_scan #(
    .DWELL_CYC (4),
    .DB_CYC    (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .col_in  (col_in),
    .row_out (row_out),
    .kbd     (kif)
  );

  always #5 clk = ~clk;

  logic [3:0] ROWS [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  logic       key_dn = 1'b0;
  logic [1:0] key_r = 2'd0;
  logic [1:0] key_c = 2'd0;
  logic       multi = 1'b0;

  int checks = 0;
  int errors = 0;
  int n_rise = 0;
  logic v_prev = 1'b0;

  // Keypad: a pressed key pulls its column low only while its row is driven.
  always_comb begin
    col_in = 4'hF;
    if (key_dn && row_out[key_r] == 1'b0) col_in[key_c] = 1'b0;
    if (multi && row_out == 4'b1110) col_in = 4'b1010;
  end

  // Count rising edges of key_valid.
  always @(negedge clk) begin
    if (kif.key_valid && !v_prev) n_rise = n_rise + 1;
    v_prev = kif.key_valid;
  end

  task automatic press_aligned(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] prev;
    int n;
    prev = row_out;
    n = 0;
    @(negedge clk);
    while (!(row_out == ROWS[r] && prev != ROWS[r]) && n < 64) begin
      prev = row_out;
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      checks++; errors++;
      $display("FAIL align_row%0d: row_out %b never reached", r, ROWS[r]);
    end
    key_r = r; key_c = c; key_dn = 1'b1;
  endtask

  task automatic wait_valid(input int maxc);
    int n;
    n = 0;
    while (kif.key_valid !== 1'b1 && n < maxc) begin
      @(negedge clk); n++;
    end
    checks++;
    if (kif.key_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_valid: key_valid %b after %0d cycles, want 1", kif.key_valid, n);
    end
  endtask

  task automatic wait_held_low(input int maxc);
    int n;
    n = 0;
    while (kif.key_held !== 1'b0 && n < maxc) begin
      @(negedge clk); n++;
    end
    checks++;
    if (kif.key_held !== 1'b0) begin
      errors++;
      $display("FAIL wait_held_low: key_held %b after %0d cycles, want 0", kif.key_held, n);
    end
  endtask

  task automatic do_ack();
    kif.key_ack = 1'b1;
    @(negedge clk);
    kif.key_ack = 1'b0;
    checks++;
    if (kif.key_valid !== 1'b0) begin
      errors++; $display("FAIL ack_valid: got %b want 0", kif.key_valid);
    end
    checks++;
    if (kif.overrun !== 1'b0) begin
      errors++; $display("FAIL ack_overrun: got %b want 0", kif.overrun);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    kif.key_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (row_out !== 4'b1110) begin
      errors++; $display("FAIL rst_row: got %b want 1110", row_out);
    end
    checks++;
    if (kif.key_code !== 4'd0) begin
      errors++; $display("FAIL rst_code: got %0d want 0", kif.key_code);
    end
    checks++;
    if (kif.key_valid !== 1'b0) begin
      errors++; $display("FAIL rst_valid: got %b want 0", kif.key_valid);
    end
    checks++;
    if (kif.key_held !== 1'b0) begin
      errors++; $display("FAIL rst_held: got %b want 0", kif.key_held);
    end
    checks++;
    if (kif.overrun !== 1'b0) begin
      errors++; $display("FAIL rst_overrun: got %b want 0", kif.overrun);
    end
  endtask

  task automatic test_idle();
    rst_n = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (row_out !== ROWS[(k / 4) % 4]) begin
        errors++;
        $display("FAIL idle_row k=%0d: got %b want %b", k, row_out, ROWS[(k / 4) % 4]);
      end
      checks++;
      if (kif.key_valid !== 1'b0) begin
        errors++; $display("FAIL idle_valid k=%0d: got %b want 0", k, kif.key_valid);
      end
    end
  endtask

  task automatic test_press();
    int r0;
    r0 = n_rise;
    press_aligned(2'd2, 2'd1);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 19) begin
        checks++;
        if (kif.key_valid !== 1'b0) begin
          errors++; $display("FAIL press_early: valid %b want 0", kif.key_valid);
        end
      end
      if (k == 20) begin
        checks++;
        if (kif.key_valid !== 1'b1) begin
          errors++; $display("FAIL press_valid: got %b want 1", kif.key_valid);
        end
        checks++;
        if (kif.key_code !== 4'd9) begin
          errors++; $display("FAIL press_code: got %0d want 9", kif.key_code);
        end
        checks++;
        if (kif.key_held !== 1'b1) begin
          errors++; $display("FAIL press_held: got %b want 1", kif.key_held);
        end
      end
    end
    key_dn = 1'b0;
    for (int j = 1; j <= 19; j++) begin
      @(negedge clk);
      if (j == 18) begin
        checks++;
        if (kif.key_held !== 1'b1) begin
          errors++; $display("FAIL rel_held_hi: got %b want 1", kif.key_held);
        end
      end
      if (j == 19) begin
        checks++;
        if (kif.key_held !== 1'b0) begin
          errors++; $display("FAIL rel_held_lo: got %b want 0", kif.key_held);
        end
        checks++;
        if (row_out !== 4'b1110) begin
          errors++; $display("FAIL rel_row: got %b want 1110", row_out);
        end
      end
    end
    checks++;
    if (n_rise - r0 != 1) begin
      errors++; $display("FAIL press_once: got %0d rises want 1", n_rise - r0);
    end
    do_ack();
  endtask

  task automatic test_bounce();
    int r0;
    r0 = n_rise;
    press_aligned(2'd1, 2'd3);
    for (int k = 1; k <= 47; k++) begin
      @(negedge clk);
      if (k == 5) key_dn = 1'b0;
      if (k == 7) key_dn = 1'b1;
      if (k == 20 || k == 39) begin
        checks++;
        if (kif.key_valid !== 1'b0) begin
          errors++; $display("FAIL bounce_early k=%0d: valid %b want 0", k, kif.key_valid);
        end
      end
      if (k == 40) begin
        checks++;
        if (kif.key_valid !== 1'b1) begin
          errors++; $display("FAIL bounce_valid: got %b want 1", kif.key_valid);
        end
        checks++;
        if (kif.key_code !== 4'd7) begin
          errors++; $display("FAIL bounce_code: got %0d want 7", kif.key_code);
        end
      end
    end
    key_dn = 1'b0;
    wait_held_low(40);
    checks++;
    if (n_rise - r0 != 1) begin
      errors++; $display("FAIL bounce_once: got %0d rises want 1", n_rise - r0);
    end
    do_ack();
  endtask

  task automatic test_two_keys();
    logic [3:0] seen;
    logic bad;
    int r0;
    seen = 4'h0;
    bad = 1'b0;
    r0 = n_rise;
    multi = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      seen = seen | ~row_out;
      if (kif.key_valid || kif.key_held) bad = 1'b1;
    end
    multi = 1'b0;
    checks++;
    if (seen !== 4'hF) begin
      errors++; $display("FAIL two_rows_seen: got %b want 1111", seen);
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("FAIL two_event: got %b want 0", bad);
    end
    checks++;
    if (n_rise != r0) begin
      errors++; $display("FAIL two_rise: got %0d want %0d", n_rise, r0);
    end
  endtask

  task automatic test_overrun();
    int n;
    press_aligned(2'd0, 2'd2);
    wait_valid(40);
    checks++;
    if (kif.key_code !== 4'd2) begin
      errors++; $display("FAIL ovr_code1: got %0d want 2", kif.key_code);
    end
    key_dn = 1'b0;
    wait_held_low(40);
    press_aligned(2'd3, 2'd3);
    n = 0;
    while (kif.key_code !== 4'd15 && n < 40) begin
      @(negedge clk); n++;
    end
    checks++;
    if (kif.key_code !== 4'd15) begin
      errors++; $display("FAIL ovr_code2: got %0d want 15", kif.key_code);
    end
    checks++;
    if (kif.overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_flag: got %b want 1", kif.overrun);
    end
    checks++;
    if (kif.key_valid !== 1'b1) begin
      errors++; $display("FAIL ovr_valid: got %b want 1", kif.key_valid);
    end
    key_dn = 1'b0;
    wait_held_low(40);
    do_ack();
  endtask

  task automatic test_ack_on_accept();
    press_aligned(2'd2, 2'd0);
    wait_valid(40);
    key_dn = 1'b0;
    wait_held_low(40);
    press_aligned(2'd2, 2'd3);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 19) kif.key_ack = 1'b1;
    end
    kif.key_ack = 1'b0;
    checks++;
    if (kif.key_valid !== 1'b1) begin
      errors++; $display("FAIL aoa_valid: got %b want 1", kif.key_valid);
    end
    checks++;
    if (kif.overrun !== 1'b0) begin
      errors++; $display("FAIL aoa_overrun: got %b want 0", kif.overrun);
    end
    checks++;
    if (kif.key_code !== 4'd11) begin
      errors++; $display("FAIL aoa_code: got %0d want 11", kif.key_code);
    end
    @(negedge clk);
    checks++;
    if (kif.key_valid !== 1'b1) begin
      errors++; $display("FAIL aoa_hold: got %b want 1", kif.key_valid);
    end
    key_dn = 1'b0;
    wait_held_low(40);
    do_ack();
  endtask

  task automatic test_reset_mid();
    int r0;
    press_aligned(2'd1, 2'd0);
    wait_valid(40);
    key_dn = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (kif.key_held !== 1'b1) begin
      errors++; $display("FAIL mid_held_pre: got %b want 1", kif.key_held);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (row_out !== 4'b1110) begin
      errors++; $display("FAIL mid_row: got %b want 1110", row_out);
    end
    checks++;
    if (kif.key_code !== 4'd0) begin
      errors++; $display("FAIL mid_code: got %0d want 0", kif.key_code);
    end
    checks++;
    if (kif.key_valid !== 1'b0) begin
      errors++; $display("FAIL mid_valid: got %b want 0", kif.key_valid);
    end
    checks++;
    if (kif.key_held !== 1'b0) begin
      errors++; $display("FAIL mid_held: got %b want 0", kif.key_held);
    end
    @(negedge clk);
    rst_n = 1'b1;
    r0 = n_rise;
    checks++;
    if (row_out !== 4'b1110) begin
      errors++; $display("FAIL mid_row_rel: got %b want 1110", row_out);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (n_rise != r0 || kif.key_valid !== 1'b0) begin
      errors++; $display("FAIL mid_spurious: rises %0d valid %b want 0 0", n_rise - r0, kif.key_valid);
    end
  endtask

  initial begin
    kif.key_ack = 1'b0;
    test_reset();
    test_idle();
    test_press();
    test_bounce();
    test_two_keys();
    test_overrun();
    test_ack_on_accept();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
